fft_reorder: RTL
================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter N, default 64, FFT point count; power of 2, N >= 4; LOG_N = log2(N).
REQ-002 Parameter WIDTH, default 16, data bit length per real/imag component.
REQ-003 clock  input  1  master clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 idata_en  input  1  input sample valid; held high for N consecutive cycles per frame.
REQ-006 idata_r  input  WIDTH  input sample, real, bit-reversed frame order.
REQ-007 idata_i  input  WIDTH  input sample, imag, bit-reversed frame order.
REQ-008 odata_en  output  1  output sample valid.
REQ-009 odata_r  output  WIDTH  output sample, real, natural frame order.
REQ-010 odata_i  output  WIDTH  output sample, imag, natural frame order.
REQ-011 frame_abort  output  1  one-cycle pulse on aborted input frame; present only with FRAME_ABORT_FLAG_EN.

Function
REQ-012 Block SHALL convert each N-sample frame from bit-reversed order, as produced by the SDF FFT cascade, to natural order.
REQ-013 Storage SHALL be ping-pong: two banks of N complex entries, one write bank and one read bank.
REQ-014 Write counter wcnt (LOG_N bits) SHALL increment on each cycle with idata_en=1; sample with wcnt=j SHALL be stored at write-bank address j.
REQ-015 idata_en=0 with wcnt!=0 SHALL abort the frame: wcnt cleared to 0, partial data discarded, banks not swapped.
REQ-016 Sample with wcnt=N-1 SHALL complete the frame: wcnt wraps to 0, banks swap, readout of the completed bank starts.
REQ-017 Readout SHALL emit output k (k=0..N-1) from read-bank address bitrev_LOG_N(k), one sample per cycle, odata_en=1 for exactly N consecutive cycles.
REQ-018 Latency: input sample j is sampled at edge e0+j; output k SHALL be valid with odata_en=1 after edge e0+N+1+k.
REQ-019 Frame completion in the same cycle as the last readout cycle SHALL start the next readout with no gap; back-to-back frames SHALL give continuous odata_en.
REQ-020 Frame completion cannot occur while a readout has more than one sample remaining, because input rate is at most 1 sample/cycle. No overlap handling SHALL be added.
REQ-021 An input frame that starts immediately after an abort SHALL be accepted normally with wcnt starting at 0.
REQ-022 odata_r/odata_i SHALL be registered; with odata_en=0 they SHALL hold their last value.
REQ-023 An abort during readout SHALL NOT affect the readout in progress.

Reset
REQ-024 reset=1 SHALL asynchronously clear wcnt, read counter, read-active flag, bank select (write bank 0), odata_en, odata_r, odata_i and frame_abort to 0.
REQ-025 Bank memory SHALL NOT be reset; contents after reset are undefined and SHALL never be emitted.
REQ-026 Reset asserted mid-readout SHALL terminate output immediately; no residual odata_en SHALL appear after release.

Configuration
REQ-027 Macro FRAME_ABORT_FLAG_EN defined: port frame_abort SHALL exist and SHALL pulse high for one cycle, on the edge following the abort condition of REQ-015.
REQ-028 Macro FRAME_ABORT_FLAG_EN undefined: port frame_abort and its logic SHALL be absent, and aborts SHALL be silent; all other behaviour is identical.

Verification
REQ-029 N=8, one frame with idata_r=j, idata_i=-j at position j -> odata_r sequence 0,4,2,6,1,5,3,7 (odata_i negated), first valid at edge e0+9.
REQ-030 N=64, three back-to-back frames with random data -> 192 contiguous odata_en cycles; each frame matches the natural-order reference model.
REQ-031 N=8, idata_en dropped after 5 samples, then a full frame -> only the full frame is output; frame_abort pulses once when the macro is defined.
REQ-032 N=8, reset asserted at output k=3 for 2 cycles, then a new frame -> odata_en=0 and data=0 immediately; new frame is output correctly with latency N+1.
REQ-033 N=4, frames with 3-cycle gaps between them -> order 0,2,1,3 per frame; odata_en low in the gaps; outputs hold their value while odata_en is low.
REQ-034 Abort during readout (previous frame outputting, new frame cut at 2 samples) -> previous frame output is unaffected and complete.

Source files
------------

// File: rtl/fft_reorder.sv
// Reorders bit-reversed FFT frames into natural order using a ping-pong pair of banks.
// Optional build macro FRAME_ABORT_FLAG_EN adds the frame_abort pulse output.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i
`ifdef FRAME_ABORT_FLAG_EN
  ,
  output logic             frame_abort
`endif
);

  localparam int             LOG_N    = $clog2(N);
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] ONE_IDX  = LOG_N'(1);
  localparam logic [LOG_N-1:0] ZERO_IDX = {LOG_N{1'b0}};

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    r = {LOG_N{1'b0}};
    for (int b = 0; b < LOG_N; b++) begin
      r[b] = a[LOG_N-1-b];
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] r_mem [2*N];
  logic [LOG_N-1:0]   r_wcnt;
  logic [LOG_N-1:0]   r_rcnt;
  logic               r_wbank;
  logic               r_rd_active;
  logic               r_rd_valid;
  logic [2*WIDTH-1:0] r_rd_data;
  logic               w_frame_done;
  logic [LOG_N:0]     w_waddr;
  logic [LOG_N:0]     w_raddr;

  // Frame completion and bank addressing; the read bank is always the one not being written.
  always_comb begin
    w_frame_done = idata_en && (r_wcnt == LAST_IDX);
    w_waddr      = {r_wbank, r_wcnt};
    w_raddr      = {~r_wbank, bitrev(r_rcnt)};
  end

  // Bank storage, deliberately without reset.
  always_ff @(posedge clock) begin
    if (idata_en) begin
      r_mem[w_waddr] <= {idata_r, idata_i};
    end
  end

  // Write counter and bank select; a gap mid-frame discards the partial frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wcnt  <= ZERO_IDX;
      r_wbank <= 1'b0;
    end else if (idata_en) begin
      r_wcnt <= r_wcnt + ONE_IDX;
      if (w_frame_done) begin
        r_wbank <= ~r_wbank;
      end
    end else begin
      r_wcnt <= ZERO_IDX;
    end
  end

  // Readout sequencer plus one-cycle synchronous bank read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_active <= 1'b0;
      r_rcnt      <= ZERO_IDX;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= {(2*WIDTH){1'b0}};
    end else begin
      r_rd_valid <= r_rd_active;
      if (r_rd_active) begin
        r_rd_data <= r_mem[w_raddr];
      end
      // A completion can only coincide with the last read, so restarting here leaves no gap.
      if (w_frame_done) begin
        r_rd_active <= 1'b1;
        r_rcnt      <= ZERO_IDX;
      end else if (r_rd_active) begin
        r_rcnt <= r_rcnt + ONE_IDX;
        if (r_rcnt == LAST_IDX) begin
          r_rd_active <= 1'b0;
        end
      end
    end
  end

  // Output registers hold their value while no sample is valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      odata_en <= 1'b0;
      odata_r  <= {WIDTH{1'b0}};
      odata_i  <= {WIDTH{1'b0}};
    end else begin
      odata_en <= r_rd_valid;
      if (r_rd_valid) begin
        odata_r <= r_rd_data[2*WIDTH-1:WIDTH];
        odata_i <= r_rd_data[WIDTH-1:0];
      end
    end
  end

`ifdef FRAME_ABORT_FLAG_EN
  logic w_abort;

  // Abort is a gap while a frame is partially written.
  always_comb begin
    w_abort = !idata_en && (r_wcnt != ZERO_IDX);
  end

  // One-cycle abort pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= w_abort;
    end
  end
`endif

endmodule
